hnf_txreq_sched: RTL and testbench

- HN-F TXREQ-channel scheduler.
- Arbitrates round-robin among NUM_SRC internal requesters (POCQ miss/allocation paths headed to SN-F) for the single TXREQ link.
- Owns the CHI L-credit counter for TXREQ and drives txreqflit/txreqflitv/txreqflitpend.
- Sits between the POCQ/SLC/SF lookup pipeline and the shhl TXREQ ports.

---
 rtl/hnf_txreq_sched_pkg.sv | 17 +
 rtl/hnf_txreq_sched_rr_arb.sv | 27 ++
 rtl/hnf_txreq_sched.sv | 103 ++++++++++
 tb/tb_hnf_txreq_sched.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hnf_txreq_sched_pkg.sv
// rtl/hnf_txreq_sched_pkg.sv - shared CHI TXREQ constants, request flit type and helpers
package hnf_txreq_sched_pkg;

    localparam int HNF_TXREQ_MAX_LCRD = 15;
    localparam int HNF_TXREQ_NUM_SRC  = 4;

    typedef struct packed {
        logic [47:0] addr;
        logic [6:0]  opcode;
        logic [7:0]  txnid;
    } reqflit_t;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/hnf_txreq_sched_rr_arb.sv
// rtl/hnf_txreq_sched_rr_arb.sv - combinational round-robin arbiter, search starts at ptr
module hnf_txreq_sched_rr_arb #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PTR_W'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hnf_txreq_sched.sv
// rtl/hnf_txreq_sched.sv - HN-F TXREQ scheduler: RR grant, L-credit counter, flit register
module hnf_txreq_sched
    import hnf_txreq_sched_pkg::*;
#(
    parameter int NUM_SRC  = HNF_TXREQ_NUM_SRC,
    parameter int MAX_LCRD = HNF_TXREQ_MAX_LCRD,
    parameter int CRD_W    = $clog2(MAX_LCRD + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_req_v,
    input  reqflit_t           src_reqflit [NUM_SRC],
    output logic [NUM_SRC-1:0] src_req_ready,
    input  logic               link_en,
    output reqflit_t           txreqflit,
    output logic               txreqflitv,
    output logic               txreqflitpend,
    input  logic               txreqlcrdv,
    output logic [CRD_W-1:0]   lcrd_cnt,
    output logic               crd_ovf
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic             pend_q,  pend_d;
    logic             flitv_q, flitv_d;
    reqflit_t         flit_q,  flit_d;
    logic [CRD_W-1:0] lcrd_q,  lcrd_d;
    logic             ovf_q,   ovf_d;
    logic [PTR_W-1:0] ptr_q,   ptr_d;

    logic               can_issue;
    logic               grant;
    logic [NUM_SRC-1:0] gnt;

    // Pend is registered, so a credit is only spendable once pend has risen on it.
    assign can_issue = pend_q & link_en & (lcrd_q != '0);

    hnf_txreq_sched_rr_arb #(
        .N     (NUM_SRC),
        .PTR_W (PTR_W)
    ) u_rr_arb (
        .req (src_req_v & {NUM_SRC{can_issue}}),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    assign grant = |gnt;

    always_comb begin
        ptr_d   = ptr_q;
        flit_d  = flit_q;
        flitv_d = grant;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gnt[i]) begin
                ptr_d  = PTR_W'(rr_next(i, NUM_SRC));
                flit_d = src_reqflit[i];
            end
        end
    end

    // Credits are spent at grant; a lone credit arriving at the ceiling is dropped and flagged.
    always_comb begin
        lcrd_d = lcrd_q;
        ovf_d  = ovf_q;
        if (txreqlcrdv && !grant) begin
            if (lcrd_q == CRD_W'(MAX_LCRD)) begin
                ovf_d = 1'b1;
            end else begin
                lcrd_d = lcrd_q + CRD_W'(1);
            end
        end else if (!txreqlcrdv && grant) begin
            lcrd_d = lcrd_q - CRD_W'(1);
        end
        pend_d = link_en & (lcrd_d != '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_q  <= 1'b0;
            flitv_q <= 1'b0;
            flit_q  <= '0;
            lcrd_q  <= '0;
            ovf_q   <= 1'b0;
            ptr_q   <= '0;
        end else begin
            pend_q  <= pend_d;
            flitv_q <= flitv_d;
            flit_q  <= flit_d;
            lcrd_q  <= lcrd_d;
            ovf_q   <= ovf_d;
            ptr_q   <= ptr_d;
        end
    end

    assign src_req_ready = gnt;
    assign txreqflit     = flit_q;
    assign txreqflitv    = flitv_q;
    assign txreqflitpend = pend_q;
    assign lcrd_cnt      = lcrd_q;
    assign crd_ovf       = ovf_q;

endmodule

// File: tb/tb_hnf_txreq_sched.sv
// tb/tb_hnf_txreq_sched.sv - self-checking bench for hnf_txreq_sched
module tb_hnf_txreq_sched;
    import hnf_txreq_sched_pkg::*;

    localparam int NUM_SRC  = 4;
    localparam int MAX_LCRD = 15;
    localparam int CRD_W    = 4;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [NUM_SRC-1:0] src_req_v = '0;
    reqflit_t           src_reqflit [NUM_SRC];
    logic [NUM_SRC-1:0] src_req_ready;
    logic               link_en = 1'b1;
    reqflit_t           txreqflit;
    logic               txreqflitv;
    logic               txreqflitpend;
    logic               txreqlcrdv = 1'b0;
    logic [CRD_W-1:0]   lcrd_cnt;
    logic               crd_ovf;

    int checks = 0;
    int errors = 0;

    int gnt_log[$];
    int txn_log[$];

    // Reference state
    int       m_lcrd = 0;
    int       m_ptr  = 0;
    bit       m_pend = 0;
    bit       m_ovf  = 0;
    bit       m_flitv = 0;
    reqflit_t m_flit;

    hnf_txreq_sched #(
        .NUM_SRC  (NUM_SRC),
        .MAX_LCRD (MAX_LCRD),
        .CRD_W    (CRD_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .src_req_v     (src_req_v),
        .src_reqflit   (src_reqflit),
        .src_req_ready (src_req_ready),
        .link_en       (link_en),
        .txreqflit     (txreqflit),
        .txreqflitv    (txreqflitv),
        .txreqflitpend (txreqflitpend),
        .txreqlcrdv    (txreqlcrdv),
        .lcrd_cnt      (lcrd_cnt),
        .crd_ovf       (crd_ovf)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_log(input string name, input int q[$], input int exp[]);
        chk({name, "_len"}, 64'(q.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < q.size(); i++)
            chk(name, 64'(q[i]), 64'(exp[i]));
    endtask

    // Cycle-level reference: compare on the falling edge, then advance with that cycle's inputs.
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                m_lcrd = 0; m_ptr = 0; m_pend = 0; m_ovf = 0; m_flitv = 0;
                chk("rst_ready", 64'(src_req_ready), 64'(0));
                chk("rst_flitv", 64'(txreqflitv), 64'(0));
                chk("rst_pend",  64'(txreqflitpend), 64'(0));
                chk("rst_lcrd",  64'(lcrd_cnt), 64'(0));
                chk("rst_ovf",   64'(crd_ovf), 64'(0));
                chk("rst_flit",  64'(txreqflit), 64'(0));
            end else begin
                int g;
                int n;
                logic [NUM_SRC-1:0] exp_ready;
                g = -1;
                exp_ready = '0;
                if (m_pend && link_en && m_lcrd != 0) begin
                    for (int k = 0; k < NUM_SRC; k++) begin
                        if (g < 0 && src_req_v[(m_ptr + k) % NUM_SRC])
                            g = (m_ptr + k) % NUM_SRC;
                    end
                end
                if (g >= 0) exp_ready[g] = 1'b1;
                chk("ready", 64'(src_req_ready), 64'(exp_ready));
                chk("flitv", 64'(txreqflitv), 64'(m_flitv));
                chk("pend",  64'(txreqflitpend), 64'(m_pend));
                chk("lcrd",  64'(lcrd_cnt), 64'(m_lcrd));
                chk("ovf",   64'(crd_ovf), 64'(m_ovf));
                if (m_flitv) chk("flit", 64'(txreqflit), 64'(m_flit));
                if (src_req_ready != '0) chk("no_underflow", 64'(lcrd_cnt != '0), 64'(1));
                for (int i = 0; i < NUM_SRC; i++)
                    if (src_req_ready[i]) gnt_log.push_back(i);
                if (txreqflitv) txn_log.push_back(int'(txreqflit.txnid));

                n = m_lcrd + int'(txreqlcrdv) - ((g >= 0) ? 1 : 0);
                if (n > MAX_LCRD) begin
                    n = MAX_LCRD;
                    m_ovf = 1;
                end
                m_lcrd  = n;
                m_pend  = link_en && (n != 0);
                m_flitv = (g >= 0);
                if (g >= 0) begin
                    m_flit = src_reqflit[g];
                    m_ptr  = (g + 1) % NUM_SRC;
                end
            end
        end
    end

    initial begin
        int e2[]  = '{0, 1, 2};
        int e4[]  = '{1, 3, 1, 3, 1, 3, 1, 3};
        for (int i = 0; i < NUM_SRC; i++)
            src_reqflit[i] = '{addr: 48'(64'h1000 * i + 64'h40), opcode: 7'h04, txnid: 8'(i)};

        // 1: reset, all valid, no credits
        cyc(); cyc();
        reset = 1'b0;
        src_req_v = 4'b1111;
        repeat (10) cyc();
        @(negedge clock);
        chk("t1_ready", 64'(src_req_ready), 64'(0));
        chk("t1_flitv", 64'(txreqflitv), 64'(0));
        chk("t1_pend",  64'(txreqflitpend), 64'(0));
        chk("t1_lcrd",  64'(lcrd_cnt), 64'(0));

        // 2: three credits, then all sources -> grants 0,1,2
        cyc(); src_req_v = '0; txreqlcrdv = 1'b1;
        repeat (3) cyc();
        txreqlcrdv = 1'b0;
        gnt_log.delete(); txn_log.delete();
        src_req_v = 4'b1111;
        @(negedge clock);
        chk("t2_lcrd3", 64'(lcrd_cnt), 64'(3));
        repeat (3) cyc();
        @(negedge clock);
        chk("t2_lcrd0", 64'(lcrd_cnt), 64'(0));
        chk("t2_pend0", 64'(txreqflitpend), 64'(0));
        cyc(); cyc();
        src_req_v = '0;
        chk_log("t2_gnt", gnt_log, e2);
        chk_log("t2_txn", txn_log, e2);

        // 3: credit arrives in the same cycle as a grant
        cyc(); txreqlcrdv = 1'b1;
        cyc(); txreqlcrdv = 1'b0;
        cyc(); src_req_v = 4'b0001; txreqlcrdv = 1'b1;
        @(negedge clock);
        chk("t3_gnt_a", 64'(src_req_ready), 64'(4'b0001));
        chk("t3_lcrd_a", 64'(lcrd_cnt), 64'(1));
        cyc(); txreqlcrdv = 1'b0;
        @(negedge clock);
        chk("t3_gnt_b", 64'(src_req_ready), 64'(4'b0001));
        chk("t3_lcrd_b", 64'(lcrd_cnt), 64'(1));
        cyc(); src_req_v = '0;
        @(negedge clock);
        chk("t3_lcrd_c", 64'(lcrd_cnt), 64'(0));

        // 4: only sources 1 and 3, eight credits
        cyc(); txreqlcrdv = 1'b1;
        repeat (8) cyc();
        txreqlcrdv = 1'b0;
        gnt_log.delete();
        src_req_v = 4'b1010;
        repeat (10) cyc();
        src_req_v = '0;
        chk_log("t4_gnt", gnt_log, e4);
        @(negedge clock);
        chk("t4_lcrd", 64'(lcrd_cnt), 64'(0));

        // 5: saturation and sticky overflow
        cyc(); txreqlcrdv = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            chk("t5_lcrd_ramp", 64'(lcrd_cnt), 64'((k > 15) ? 15 : k));
            chk("t5_ovf_ramp", 64'(crd_ovf), 64'(0));
            cyc();
        end
        txreqlcrdv = 1'b0;
        @(negedge clock);
        chk("t5_lcrd_sat", 64'(lcrd_cnt), 64'(15));
        chk("t5_ovf_set", 64'(crd_ovf), 64'(1));
        repeat (3) cyc();
        @(negedge clock);
        chk("t5_ovf_sticky", 64'(crd_ovf), 64'(1));
        cyc(); reset = 1'b1;
        @(negedge clock);
        chk("t5_rst_lcrd", 64'(lcrd_cnt), 64'(0));
        chk("t5_rst_ovf", 64'(crd_ovf), 64'(0));
        cyc(); reset = 1'b0;

        // 6: link_en drop and re-assert
        cyc(); txreqlcrdv = 1'b1;
        repeat (6) cyc();
        txreqlcrdv = 1'b0;
        src_req_v = 4'b1111;
        @(negedge clock);
        chk("t6_gnt_pre", 64'(src_req_ready), 64'(4'b0001));
        cyc(); link_en = 1'b0;
        @(negedge clock);
        chk("t6_nogrant", 64'(src_req_ready), 64'(0));
        chk("t6_inflight", 64'(txreqflitv), 64'(1));
        chk("t6_lcrd5", 64'(lcrd_cnt), 64'(5));
        repeat (4) begin
            cyc();
            @(negedge clock);
            chk("t6_hold_ready", 64'(src_req_ready), 64'(0));
            chk("t6_hold_pend", 64'(txreqflitpend), 64'(0));
            chk("t6_hold_lcrd", 64'(lcrd_cnt), 64'(5));
        end
        cyc(); link_en = 1'b1;
        @(negedge clock);
        chk("t6_reen_ready", 64'(src_req_ready), 64'(0));
        cyc();
        @(negedge clock);
        chk("t6_reen_pend", 64'(txreqflitpend), 64'(1));
        chk("t6_reen_gnt", 64'(src_req_ready), 64'(4'b0010));
        cyc(); src_req_v = '0;
        repeat (3) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
